// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with runtime pattern and length.
// Supports overlap and non-overlap modes, an input-valid qualifier, and a saturating match counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b1011),
    parameter int                 DEF_LEN = 4,
    parameter logic               DEF_OVL = 1'b1,
    localparam int                LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_valid_i,
    input  logic               in_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LW-1:0]      cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               count_clr_i,
    output logic               detect_o,
    output logic [CNT_W-1:0]   match_count_o
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               match;
    logic [LW-1:0]      lenClamp;
    logic [LW-1:0]      fillInc;
    logic [MAX_LEN-1:0] histShift;
    logic [MAX_LEN-1:0] lenMask;

    always_comb begin
        lenClamp = cfg_len_i;
        if (cfg_len_i == '0) begin
            lenClamp = LW'(1);
        end else if (cfg_len_i > LW'(MAX_LEN)) begin
            lenClamp = LW'(MAX_LEN);
        end

        // A config load wins over a same-edge sample, so that sample is never seen.
        accept    = in_valid_i & ~cfg_load_i;
        histShift = {hist_q[MAX_LEN-2:0], in_i};
        fillInc   = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
        lenMask   = ~({MAX_LEN{1'b1}} << len_q);
        match     = accept && (fillInc == len_q) &&
                    (((histShift ^ pat_q) & lenMask) == '0);

        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        detect_d = 1'b0;

        if (cfg_load_i) begin
            pat_d  = cfg_pattern_i;
            len_d  = lenClamp;
            ovl_d  = cfg_overlap_i;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d   = histShift;
            fill_d   = (match && !ovl_q) ? '0 : fillInc;
            detect_d = match;
        end

        count_d = count_q;
        if (count_clr_i) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pat_q    <= DEF_PAT;
            len_q    <= LW'(DEF_LEN);
            ovl_q    <= DEF_OVL;
            hist_q   <= '0;
            fill_q   <= '0;
            detect_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            detect_q <= detect_d;
            count_q  <= count_d;
        end
    end

    assign detect_o      = detect_q;
    assign match_count_o = count_q;

endmodule
